bpd_update_arbiter_rr: RTL and testbench
========================================

Name: bpd_update_arbiter_rr

Overview:
- Parametrised N-way arbiter for branch-predictor update bundles feeding the predictor update port.
- Generalises the two-input fixed-priority update arbiter:
  - N inputs;
  - runtime-selectable fixed-priority or round-robin mode;
  - an urgent (mispredict/repair) override class;
  - a registered output FIFO that breaks the ready/valid combinational path;
  - a flush.

Parameters:
- N_IN, 4, number of input channels (≥2).
- DATA_W, 256, width of one flattened update bundle.
- DEPTH, 2, output FIFO entries (power of 2, ≥2).
- CHOSEN_W, clog2(N_IN), width of channel index.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- io_mode_rr  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- io_flush  in  1  synchronous clear of FIFO contents
- io_in_valid  in  N_IN  per-channel valid
- io_in_urgent  in  N_IN  per-channel urgent flag; only meaningful with valid
- io_in_bits  in  N_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- io_in_ready  out  N_IN  per-channel ready
- io_out_ready  in  1  consumer ready
- io_out_valid  out  1  FIFO head valid
- io_out_bits  out  DATA_W  FIFO head payload
- io_out_chosen  out  CHOSEN_W  channel index that produced the head entry
- io_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (clock edge with reset=1):
  - count=0, rr_ptr=0.
  - io_out_valid=0, io_out_bits=0, io_out_chosen=0, io_count=0.
  - All io_in_ready=0 during reset.
  - FIFO storage is not reset.
- Output gating: io_out_bits and io_out_chosen are forced to 0 whenever io_out_valid=0.
- Candidate set:
  - U = io_in_valid & io_in_urgent.
  - C = U if U≠0, else C = io_in_valid.
  - Urgent requests always beat non-urgent ones in both modes.
- Fixed mode: winner = lowest set index of C.
- RR mode:
  - Winner = first set index of C scanning rr_ptr, rr_ptr+1, … wrapping modulo N_IN.
- Grant and accept:
  - can_enq = (count < DEPTH) & ~io_flush & ~reset. count is registered, so there is no combinational path from io_out_ready to io_in_ready.
  - io_in_ready[i] = can_enq & (i == winner) & (C≠0). At most one bit is set.
  - fire = |(io_in_ready & io_in_valid).
- Pointer update:
  - On fire, rr_ptr <= (winner+1) mod N_IN, in both modes. Urgent grants advance it too.
  - rr_ptr is unchanged otherwise. Switching mode never resets the pointer.
- FIFO:
  - On fire, {bits of winner, winner} is written at wr_ptr.
  - Dequeue when io_out_valid & io_out_ready.
  - Accept-to-output latency is exactly 1 cycle when the FIFO was empty.
  - Ordering is strict FIFO.
- Full: count==DEPTH blocks enqueue for that cycle even if a dequeue occurs in the same cycle. Registered ready is required.
- Simultaneous enq+deq with 0<count<DEPTH: count unchanged, both pointers advance. wr/rd pointers wrap modulo DEPTH.
- Empty: io_out_valid=0, and dequeue is ignored.
- io_flush=1:
  - Next cycle count=0 and rd/wr pointers are equal.
  - No enqueue in the flush cycle (ready=0), and any dequeue in that cycle is discarded.
  - rr_ptr is retained.
- Reset asserted mid-operation: all in-flight entries are lost and the reset values above apply on the next cycle.
- io_in_urgent on a channel with valid=0 is ignored.
- Inputs must hold bits stable while valid and not ready (standard decoupled). The arbiter itself may change winner between cycles; it is not locking.

Test Plan:
- Fixed mode, N_IN=4, valid=4'b1010, out_ready=1 → ready=4'b0010; next cycle out_valid=1, out_chosen=1, out_bits=ch1 payload. Hold 5 cycles → ch3 never granted.
- RR mode, valid=4'b1111 held, out_ready=1 → chosen sequence 0,1,2,3,0,… with one grant per cycle after a 1-cycle fill latency.
- RR mode, rr_ptr=2, valid=4'b1111, urgent=4'b0001 → ch0 granted and rr_ptr becomes 1. With urgent then cleared, the next grant is ch1.
- out_ready=0, all valid, DEPTH=2 → two accepts, then io_count=2 and io_in_ready=0. Raising out_ready for one cycle gives a dequeue with no enqueue that cycle, then a refill the next cycle.
- count=2, io_flush=1 concurrent with out_ready=1 and valid=4'b0001 → next cycle io_count=0, out_valid=0, out_bits=0, no enqueue recorded, rr_ptr unchanged.
- Assert reset for 1 cycle with count=1 and rr_ptr=3 → io_count=0, out_valid=0, in_ready=0 during reset. After release, RR grants start from ch0.

Source files
------------

// File: rtl/bpd_update_arbiter_rr_if.sv
// rtl/bpd_update_arbiter_rr_if.sv - update-channel and output-port bundle for the update arbiter
// Ports (slave = arbiter view):
//   io_in_valid/io_in_urgent/io_in_bits  N_IN request channels, bits flattened per channel
//   io_in_ready                          per-channel grant/accept
//   io_out_valid/io_out_bits/io_out_chosen/io_out_ready  FIFO head towards the predictor
interface bpd_update_arbiter_rr_if #(
    parameter int N_IN     = 4,
    parameter int DATA_W   = 256,
    parameter int CHOSEN_W = $clog2(N_IN)
);
    logic [N_IN-1:0]        io_in_valid;
    logic [N_IN-1:0]        io_in_urgent;
    logic [N_IN*DATA_W-1:0] io_in_bits;
    logic [N_IN-1:0]        io_in_ready;
    logic                   io_out_ready;
    logic                   io_out_valid;
    logic [DATA_W-1:0]      io_out_bits;
    logic [CHOSEN_W-1:0]    io_out_chosen;

    modport master (
        output io_in_valid, io_in_urgent, io_in_bits, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_chosen
    );

    modport slave (
        input  io_in_valid, io_in_urgent, io_in_bits, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_chosen
    );
endinterface

// File: rtl/bpd_update_arbiter_rr.sv
// rtl/bpd_update_arbiter_rr.sv - N-way fixed/round-robin update arbiter with urgent class and output FIFO
// Ports:
//   clock, reset   core clock, synchronous active-high reset
//   io_mode_rr     0 = fixed priority (lowest index), 1 = round-robin from rr_ptr
//   io_flush       synchronous clear of the output FIFO (rr_ptr kept)
//   upd            request channels and FIFO head (slave modport)
//   io_count       FIFO occupancy
module bpd_update_arbiter_rr #(
    parameter int N_IN     = 4,
    parameter int DATA_W   = 256,
    parameter int DEPTH    = 2,
    parameter int CHOSEN_W = $clog2(N_IN)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_mode_rr,
    input  logic                     io_flush,
    bpd_update_arbiter_rr_if.slave   upd,
    output logic [$clog2(DEPTH):0]   io_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]   data_q   [DEPTH];
    logic [CHOSEN_W-1:0] chosen_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CHOSEN_W-1:0] rr_ptr;

    logic [N_IN-1:0]     urg;
    logic [N_IN-1:0]     cand;
    logic [CHOSEN_W-1:0] winner;
    logic [CHOSEN_W-1:0] winner_next;
    logic                found;
    logic                can_enq;
    logic                fire;
    logic                deq;
    int                  idx;

    // Urgent requests form their own class; only when none exist do plain
    // requests compete. The scan starts at rr_ptr in round-robin mode and at
    // index 0 in fixed mode, so both modes share one priority search.
    always_comb begin
        urg    = upd.io_in_valid & upd.io_in_urgent;
        cand   = (urg != '0) ? urg : upd.io_in_valid;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = (io_mode_rr ? int'(rr_ptr) : 0) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = CHOSEN_W'(idx);
            end
        end
        winner_next = (int'(winner) == N_IN - 1) ? '0 : winner + 1'b1;
    end

    // Enqueue eligibility looks only at the registered count, so a full FIFO
    // stays closed even when the consumer drains it in the same cycle; this
    // keeps io_out_ready out of the io_in_ready path.
    assign can_enq = (count < CNT_W'(DEPTH)) && !io_flush && !reset;

    always_comb begin
        upd.io_in_ready = '0;
        if (can_enq && found) begin
            upd.io_in_ready[winner] = 1'b1;
        end
    end

    assign fire = |(upd.io_in_ready & upd.io_in_valid);
    assign deq  = upd.io_out_valid && upd.io_out_ready;

    assign upd.io_out_valid  = (count != '0);
    assign upd.io_out_bits   = upd.io_out_valid ? data_q[rd_ptr]   : '0;
    assign upd.io_out_chosen = upd.io_out_valid ? chosen_q[rd_ptr] : '0;
    assign io_count          = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else if (io_flush) begin
            // Dequeue in the flush cycle is discarded; rr_ptr survives.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= winner_next;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fire, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; contents are only visible through
    // count-qualified output gating.
    always_ff @(posedge clock) begin
        if (fire) begin
            data_q[wr_ptr]   <= upd.io_in_bits[winner*DATA_W +: DATA_W];
            chosen_q[wr_ptr] <= winner;
        end
    end
endmodule

// File: tb/tb_bpd_update_arbiter_rr.sv
// tb/tb_bpd_update_arbiter_rr.sv - randomized and directed bench for bpd_update_arbiter_rr against a queue model
module tb_bpd_update_arbiter_rr;
    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_mode_rr;
    logic       io_flush;
    logic [2:0] io_count;

    bpd_update_arbiter_rr_if #(.N_IN(N), .DATA_W(DW), .CHOSEN_W(CW)) upd();

    bpd_update_arbiter_rr #(.N_IN(N), .DATA_W(DW), .DEPTH(DEPTH), .CHOSEN_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_mode_rr (io_mode_rr),
        .io_flush   (io_flush),
        .upd        (upd.slave),
        .io_count   (io_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: a queue of accepted entries and the round-robin pointer.
    logic [DW-1:0] q_bits [$];
    int            q_chan [$];
    int            m_rr;
    logic [DW-1:0] chan_bits [N];
    logic [N-1:0]  prev_valid;
    logic [N-1:0]  prev_grant;
    string         phase;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    // Urgent class first; within the class pick the request closest to the
    // scan start (index 0 in fixed mode, m_rr in round-robin mode).
    function automatic int model_pick(input logic [N-1:0] v, input logic [N-1:0] u, input bit rr, input int ptr);
        logic [N-1:0] c;
        int best;
        int bestd;
        int d;
        c     = ((v & u) != '0) ? (v & u) : v;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                d = rr ? ((i - ptr + N) % N) : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance model at the edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] u, input bit oready,
                         input bit fl, input bit rst, input bit rr);
        int           w;
        logic [N-1:0] exp_ready;
        bit           exp_valid;
        bit           do_deq;
        for (int i = 0; i < N; i++) begin
            if (!(prev_valid[i] && !prev_grant[i])) begin
                chan_bits[i] = {$urandom, $urandom};
            end
            upd.io_in_bits[i*DW +: DW] = chan_bits[i];
        end
        upd.io_in_valid  = v;
        upd.io_in_urgent = u;
        upd.io_out_ready = oready;
        io_flush         = fl;
        reset            = rst;
        io_mode_rr       = rr;
        #4;
        exp_valid = (q_bits.size() > 0);
        check("out_valid", 256'(upd.io_out_valid), 256'(exp_valid));
        check("out_bits", 256'(upd.io_out_bits), exp_valid ? 256'(q_bits[0]) : 256'(0));
        check("out_chosen", 256'(upd.io_out_chosen), exp_valid ? 256'(q_chan[0]) : 256'(0));
        check("count", 256'(io_count), 256'(q_bits.size()));
        w         = model_pick(v, u, rr, m_rr);
        exp_ready = '0;
        if (!rst && !fl && q_bits.size() < DEPTH && w >= 0) begin
            exp_ready[w] = 1'b1;
        end
        check("in_ready", 256'(upd.io_in_ready), 256'(exp_ready));
        do_deq     = exp_valid && oready;
        prev_valid = v;
        prev_grant = exp_ready & v;
        if (rst) begin
            q_bits.delete();
            q_chan.delete();
            m_rr = 0;
        end else if (fl) begin
            q_bits.delete();
            q_chan.delete();
        end else begin
            if (do_deq) begin
                void'(q_bits.pop_front());
                void'(q_chan.pop_front());
            end
            if (exp_ready != '0) begin
                q_bits.push_back(chan_bits[w]);
                q_chan.push_back(w);
                m_rr = (w + 1) % N;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        phase            = "init";
        prev_valid       = '0;
        prev_grant       = '0;
        m_rr             = 0;
        reset            = 1'b1;
        io_flush         = 1'b0;
        io_mode_rr       = 1'b0;
        upd.io_in_valid  = '0;
        upd.io_in_urgent = '0;
        upd.io_in_bits   = '0;
        upd.io_out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

        phase = "fixed";
        repeat (6) cycle(4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        phase = "rr_seq";
        repeat (10) cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

        phase = "urgent";
        cycle(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

        phase = "full";
        repeat (4) cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "flush";
        cycle(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

        phase = "reset_mid";
        cycle(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (5) cycle(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] v;
            logic [N-1:0] u;
            v = N'($urandom);
            u = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cycle(v, u, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 150) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
